// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the instruction-register fields and the multicycle control FSM.
// The FSM uses the slave modport; whatever supplies the instruction fields uses master.
interface multicycle_control_fsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       NextPC;
    logic       Branch;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUControl;
    logic [1:0] FlagW;
    logic       dontWrite;
    logic       Trap;

    modport master (
        output Op, Funct, Rd,
        input  NextPC, Branch, PCS, RegW, MemW, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, FlagW, dontWrite, Trap
    );

    modport slave (
        input  Op, Funct, Rd,
        output NextPC, Branch, PCS, RegW, MemW, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, FlagW, dontWrite, Trap
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multicycle ARM-subset core: state sequencing, mux selects, ALU decode.
// Optional macro CTRL_TRAP_EN: Op=11 halts in TRAP (Trap=1) instead of acting as a 2-cycle NOP.
module multicycle_control_fsm (
    input  logic                          clk,
    input  logic                          reset_n,
    multicycle_control_fsm_if.slave       bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
`ifdef CTRL_TRAP_EN
        , S_TRAP = 4'd10
`endif
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic       w_next_pc, w_branch, w_reg_w, w_mem_w, w_ir_write, w_adr_src;
    logic       w_alu_src_a, w_alu_op, w_dont_write, w_trap;
    logic [1:0] w_result_src, w_alu_src_b, w_imm_src, w_reg_src, w_alu_ctrl, w_flag_w;

    // State register; reset drops straight into FETCH, abandoning any in-flight instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state sequencing.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    2'b00:   w_next = bus.Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
`ifdef CTRL_TRAP_EN
                    2'b11:   w_next = S_TRAP;
`else
                    2'b11:   w_next = S_FETCH;
`endif
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = S_FETCH;
            S_EXECR:  w_next = S_ALUWB;
            S_EXECI:  w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
`ifdef CTRL_TRAP_EN
            S_TRAP:   w_next = S_TRAP;
`endif
            default:  w_next = S_FETCH;
        endcase
    end

    // Per-state datapath controls.
    always_comb begin
        w_next_pc    = 1'b0;
        w_branch     = 1'b0;
        w_reg_w      = 1'b0;
        w_mem_w      = 1'b0;
        w_ir_write   = 1'b0;
        w_adr_src    = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_op     = 1'b0;
        w_trap       = 1'b0;
        w_result_src = 2'b00;
        w_alu_src_b  = 2'b00;
        w_imm_src    = bus.Op;
        w_reg_src    = {(bus.Op == 2'b01), (bus.Op == 2'b10)};
        case (r_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_next_pc    = 1'b1;
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
            end
            S_DECODE: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
            end
            S_MEMADR: w_alu_src_b = 2'b01;
            S_MEMRD:  w_adr_src = 1'b1;
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_w      = 1'b1;
            end
            S_MEMWR: begin
                w_adr_src = 1'b1;
                w_mem_w   = 1'b1;
            end
            S_EXECR:  w_alu_op = 1'b1;
            S_EXECI: begin
                w_alu_src_b = 2'b01;
                w_alu_op    = 1'b1;
            end
            // ALU decode stays live through writeback so dontWrite lines up with RegW.
            S_ALUWB: begin
                w_reg_w  = 1'b1;
                w_alu_op = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_b  = 2'b01;
                w_result_src = 2'b10;
                w_branch     = 1'b1;
            end
`ifdef CTRL_TRAP_EN
            S_TRAP: begin
                w_trap    = 1'b1;
                w_imm_src = 2'b00;
                w_reg_src = 2'b00;
            end
`endif
            default: begin
                w_alu_op = 1'b0;
            end
        endcase
    end

    // ALU control and flag-write decode from the data-processing cmd field.
    always_comb begin
        w_alu_ctrl   = 2'b00;
        w_flag_w     = 2'b00;
        w_dont_write = 1'b0;
        if (w_alu_op) begin
            case (bus.Funct[4:1])
                4'b0100: begin
                    w_alu_ctrl = 2'b00;
                    w_flag_w   = {bus.Funct[0], bus.Funct[0]};
                end
                4'b0010: begin
                    w_alu_ctrl = 2'b01;
                    w_flag_w   = {bus.Funct[0], bus.Funct[0]};
                end
                4'b0000: begin
                    w_alu_ctrl = 2'b10;
                    w_flag_w   = {bus.Funct[0], 1'b0};
                end
                4'b1100: begin
                    w_alu_ctrl = 2'b11;
                    w_flag_w   = {bus.Funct[0], 1'b0};
                end
                4'b1010: begin
                    w_alu_ctrl   = 2'b01;
                    w_flag_w     = {bus.Funct[0], bus.Funct[0]};
                    w_dont_write = 1'b1;
                end
                default: begin
                    w_alu_ctrl = 2'b00;
                    w_flag_w   = 2'b00;
                end
            endcase
        end else begin
            w_alu_ctrl   = 2'b00;
            w_flag_w     = 2'b00;
            w_dont_write = 1'b0;
        end
    end

    assign bus.NextPC     = w_next_pc;
    assign bus.Branch     = w_branch;
    assign bus.PCS        = ((bus.Rd == 4'd15) & w_reg_w) | w_branch;
    assign bus.RegW       = w_reg_w;
    assign bus.MemW       = w_mem_w;
    assign bus.IRWrite    = w_ir_write;
    assign bus.AdrSrc     = w_adr_src;
    assign bus.ResultSrc  = w_result_src;
    assign bus.ALUSrcA    = w_alu_src_a;
    assign bus.ALUSrcB    = w_alu_src_b;
    assign bus.ImmSrc     = w_imm_src;
    assign bus.RegSrc     = w_reg_src;
    assign bus.ALUControl = w_alu_ctrl;
    assign bus.FlagW      = w_flag_w;
    assign bus.dontWrite  = w_dont_write;
    assign bus.Trap       = w_trap;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks LDR, STR, data-processing, B and Op=11
// instructions cycle by cycle and compares the full output bundle against hand-written vectors.
module tb_multicycle_control_fsm;

    logic clk;
    logic reset_n;
    int   n_assert;
    int   n_fail;

    multicycle_control_fsm_if intf ();

    multicycle_control_fsm dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed bundle: {NextPC,Branch,PCS,RegW,MemW,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,
    //                   ImmSrc,RegSrc,ALUControl,FlagW,dontWrite,Trap}
    logic [21:0] obs_vec;
    assign obs_vec = {intf.NextPC, intf.Branch, intf.PCS, intf.RegW, intf.MemW, intf.IRWrite,
                      intf.AdrSrc, intf.ResultSrc, intf.ALUSrcA, intf.ALUSrcB, intf.ImmSrc,
                      intf.RegSrc, intf.ALUControl, intf.FlagW, intf.dontWrite, intf.Trap};

    // Expected bundle; ImmSrc/RegSrc follow the Op the bench is currently driving (zero in TRAP).
    function automatic logic [21:0] ev(
        input logic npc, input logic br, input logic pcs, input logic regw, input logic memw,
        input logic irw, input logic adr, input logic [1:0] rs, input logic srca,
        input logic [1:0] srcb, input logic [1:0] aluc, input logic [1:0] flw,
        input logic dw, input logic trap);
        logic [1:0] imm;
        logic [1:0] rsrc;
        imm  = trap ? 2'b00 : intf.Op;
        rsrc = trap ? 2'b00 : {(intf.Op == 2'b01), (intf.Op == 2'b10)};
        return {npc, br, pcs, regw, memw, irw, adr, rs, srca, srcb, imm, rsrc, aluc, flw, dw, trap};
    endfunction

    function automatic logic [21:0] v_fetch();
        return ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
    endfunction

    function automatic logic [21:0] v_decode();
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
    endfunction

    task automatic check(input string tag, input logic [21:0] expv);
        n_assert++;
        assert (obs_vec === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs_vec, expv);
        end
    endtask

    task automatic step(input string tag, input logic [21:0] expv);
        @(posedge clk);
        #1;
        check(tag, expv);
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
        intf.Op    = op;
        intf.Funct = funct;
        intf.Rd    = rd;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        set_instr(2'b01, 6'b011001, 4'd3);
        #2;
        check("reset_fetch", v_fetch());
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("post_reset_fetch", v_fetch());

        // LDR R3: 5 cycles, RegW only in MEMWB with ResultSrc=01
        step("ldr_decode", v_decode());
        step("ldr_memadr", ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0));
        step("ldr_memrd",  ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0));
        step("ldr_memwb",  ev(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0));
        step("ldr_fetch", v_fetch());

        // STR: 4 cycles, MemW in MEMWR
        set_instr(2'b01, 6'b011000, 4'd3);
        step("str_decode", v_decode());
        step("str_memadr", ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0));
        step("str_memwr",  ev(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0));
        step("str_fetch", v_fetch());

        // ADDS R15 (register form): PCS with RegW in ALUWB, FlagW=11
        set_instr(2'b00, 6'b001001, 4'd15);
        step("adds_decode", v_decode());
        step("adds_execr", ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,2'b11,1'b0,1'b0));
        step("adds_aluwb", ev(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,2'b11,1'b0,1'b0));
        step("adds_fetch", v_fetch());

        // CMP: SUB, FlagW=11, dontWrite through EXECR and ALUWB
        set_instr(2'b00, 6'b010101, 4'd0);
        step("cmp_decode", v_decode());
        step("cmp_execr", ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b01,2'b11,1'b1,1'b0));
        step("cmp_aluwb", ev(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b01,2'b11,1'b1,1'b0));
        step("cmp_fetch", v_fetch());

        // ORR immediate, no S: EXECI with ExtImm, FlagW=00
        set_instr(2'b00, 6'b111000, 4'd2);
        step("orr_decode", v_decode());
        step("orr_execi", ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b11,2'b00,1'b0,1'b0));
        step("orr_aluwb", ev(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b11,2'b00,1'b0,1'b0));
        step("orr_fetch", v_fetch());

        // ANDS: logical op writes NZ only
        set_instr(2'b00, 6'b000001, 4'd4);
        step("ands_decode", v_decode());
        step("ands_execr", ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b10,2'b10,1'b0,1'b0));
        step("ands_aluwb", ev(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b10,2'b10,1'b0,1'b0));
        step("ands_fetch", v_fetch());

        // Undecoded cmd (0001) with S=1: ALUControl=00, FlagW=00
        set_instr(2'b00, 6'b000011, 4'd5);
        step("eor_decode", v_decode());
        step("eor_execr", ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0));
        step("eor_aluwb", ev(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0));
        step("eor_fetch", v_fetch());

        // B: 3 cycles, Branch=PCS=1
        set_instr(2'b10, 6'b101000, 4'd0);
        step("b_decode", v_decode());
        step("b_branch", ev(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b10,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0));
        step("b_fetch", v_fetch());

        // Op=11
        set_instr(2'b11, 6'b000000, 4'd0);
        step("op11_decode", v_decode());
`ifdef CTRL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            step("op11_trap", ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1));
        end
`else
        step("op11_nop_fetch", v_fetch());
        step("op11_next_decode", v_decode());
        step("op11_back_fetch", v_fetch());
`endif

        // Asynchronous reset in the middle of an LDR (during MEMRD)
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        set_instr(2'b01, 6'b011001, 4'd3);
        #1;
        check("pre_rst_fetch", v_fetch());
        step("rst_ldr_decode", v_decode());
        step("rst_ldr_memadr", ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0));
        step("rst_ldr_memrd",  ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_fetch", v_fetch());
        step("reset_held_fetch", v_fetch());
        @(negedge clk);
        reset_n = 1'b1;
        step("restart_decode", v_decode());
        step("restart_memadr", ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
